// File: rtl/vga_scan_renderer_pkg.sv
// Shared types and constants for the VGA scan renderer.
// Entity codes match the game logic's pixel-query encoding.
package vga_scan_renderer_pkg;

   typedef enum logic [1:0] {
      ENT_NOTHING    = 2'd0,
      ENT_SNAKE_HEAD = 2'd1,
      ENT_SNAKE_TAIL = 2'd2,
      ENT_APPLE      = 2'd3
   } entity_e;

   typedef enum logic [1:0] {
      ST_NORMAL = 2'd0,
      ST_OVER   = 2'd1,
      ST_WON    = 2'd2
   } status_e;

   // Per-pixel decode that travels alongside the entity query
   typedef struct packed {
      logic active;
      logic hs_n;
      logic vs_n;
      logic border;
   } scan_t;

   localparam scan_t SCAN_IDLE = '{
      active: 1'b0,
      hs_n:   1'b1,
      vs_n:   1'b1,
      border: 1'b0
   };

   localparam logic [11:0] COL_HEAD    = 12'h0F0;
   localparam logic [11:0] COL_TAIL    = 12'h0A0;
   localparam logic [11:0] COL_APPLE   = 12'hF00;
   localparam logic [11:0] COL_WALL    = 12'h888;
   localparam logic [11:0] COL_BG      = 12'h000;
   localparam logic [11:0] COL_BG_OVER = 12'h400;
   localparam logic [11:0] COL_BG_WON  = 12'h004;

   localparam int VGA_H_VIS  = 640;
   localparam int VGA_H_FP   = 16;
   localparam int VGA_H_SYNC = 96;
   localparam int VGA_H_BP   = 48;
   localparam int VGA_V_VIS  = 480;
   localparam int VGA_V_FP   = 10;
   localparam int VGA_V_SYNC = 2;
   localparam int VGA_V_BP   = 33;
   localparam int VGA_BORDER = 16;

   // game_over dominates game_won
   function automatic status_e next_status(
      input logic over,
      input logic won
   );
      if (over) return ST_OVER;
      if (won)  return ST_WON;
      return ST_NORMAL;
   endfunction

   function automatic logic [11:0] bg_colour(input status_e s);
      case (s)
         ST_OVER: return COL_BG_OVER;
         ST_WON:  return COL_BG_WON;
         default: return COL_BG;
      endcase
   endfunction

endpackage

// File: rtl/vga_scan_renderer_timing.sv
// Raster counters and per-pixel timing decode.
// frame_tick is aligned to the counters, not to the pins.
module vga_timing
   import vga_scan_renderer_pkg::*;
#(
   parameter int H_VIS     = VGA_H_VIS,
   parameter int H_FP      = VGA_H_FP,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BP      = VGA_H_BP,
   parameter int V_VIS     = VGA_V_VIS,
   parameter int V_FP      = VGA_V_FP,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BP      = VGA_V_BP,
   parameter int BORDER_PX = VGA_BORDER
)(
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output scan_t      scan,
   output logic       frame_tick
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
   localparam logic [9:0] H_ACT  = 10'(H_VIS);
   localparam logic [9:0] V_ACT  = 10'(V_VIS);
   localparam logic [9:0] HS_LO  = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_HI  = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_LO  = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_HI  = 10'(V_VIS + V_FP + V_SYNC - 1);
   localparam logic [9:0] B_LO   = 10'(BORDER_PX);
   localparam logic [9:0] BH_HI  = 10'(H_VIS - BORDER_PX);
   localparam logic [9:0] BV_HI  = 10'(V_VIS - BORDER_PX);

   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   logic       act;

   // Horizontal counter wraps every line and carries into the vertical one
   always_comb begin
      h_d = h_q + 10'd1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign act = (h_q < H_ACT) && (v_q < V_ACT);

   // Decode of the current counter position
   always_comb begin
      scan.active = act;
      scan.hs_n   = !((h_q >= HS_LO) && (h_q <= HS_HI));
      scan.vs_n   = !((v_q >= VS_LO) && (v_q <= VS_HI));
      scan.border = act && ((h_q < B_LO) || (h_q >= BH_HI) ||
                            (v_q < B_LO) || (v_q >= BV_HI));
   end

   assign frame_tick = (h_q == '0) && (v_q == V_ACT);
   assign h_cnt      = h_q;
   assign v_cnt      = v_q;

endmodule

// File: rtl/vga_scan_renderer.sv
// Pixel-query initiator: scans the raster, maps entity codes to RGB.
// Sync and colour share a 2-stage pipeline so they stay aligned.
module vga_scan_renderer
   import vga_scan_renderer_pkg::*;
#(
   parameter int H_VIS     = VGA_H_VIS,
   parameter int H_FP      = VGA_H_FP,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BP      = VGA_H_BP,
   parameter int V_VIS     = VGA_V_VIS,
   parameter int V_FP      = VGA_V_FP,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BP      = VGA_V_BP,
   parameter int BORDER_PX = VGA_BORDER
)(
   input  logic       vga_clk,
   input  logic       reset,
   input  logic [1:0] entity,
   input  logic       game_over,
   input  logic       game_won,
   output logic [9:0] x_out,
   output logic [9:0] y_out,
   output logic       hsync,
   output logic       vsync,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b,
   output logic       frame_tick
);

   scan_t       scan;
   scan_t       s1_q, s1_d;
   logic [11:0] rgb_q, rgb_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   status_e     status_q, status_d;
   entity_e     ent;

   vga_timing #(
      .H_VIS     (H_VIS),
      .H_FP      (H_FP),
      .H_SYNC    (H_SYNC),
      .H_BP      (H_BP),
      .V_VIS     (V_VIS),
      .V_FP      (V_FP),
      .V_SYNC    (V_SYNC),
      .V_BP      (V_BP),
      .BORDER_PX (BORDER_PX)
   ) u_timing (
      .clk        (vga_clk),
      .reset      (reset),
      .h_cnt      (x_out),
      .v_cnt      (y_out),
      .scan       (scan),
      .frame_tick (frame_tick)
   );

   assign ent = entity_e'(entity);

   // Stage 1 holds the decode while the entity answer comes back
   always_comb begin
      s1_d = scan;
   end

   // Stage 2: colour select and sync pass-through
   always_comb begin
      rgb_d   = 12'h000;
      hsync_d = s1_q.hs_n;
      vsync_d = s1_q.vs_n;
      if (s1_q.active) begin
         case (ent)
            ENT_SNAKE_HEAD: rgb_d = COL_HEAD;
            ENT_APPLE:      rgb_d = COL_APPLE;
            ENT_SNAKE_TAIL: rgb_d = COL_TAIL;
            default: begin
               rgb_d = s1_q.border ? COL_WALL
                                   : bg_colour(status_q);
            end
         endcase
      end
   end

   // Status only changes on the frame tick, so a frame never tears
   always_comb begin
      status_d = status_q;
      if (frame_tick) begin
         status_d = next_status(game_over, game_won);
      end
   end

   // Pipeline and status registers
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         s1_q     <= SCAN_IDLE;
         rgb_q    <= '0;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         status_q <= ST_NORMAL;
      end else begin
         s1_q     <= s1_d;
         rgb_q    <= rgb_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         status_q <= status_d;
      end
   end

   assign hsync = hsync_q;
   assign vsync = vsync_q;
   assign vga_r = rgb_q[11:8];
   assign vga_g = rgb_q[7:4];
   assign vga_b = rgb_q[3:0];

endmodule

// File: tb/tb_vga_scan_renderer.sv
// Scoreboard bench for vga_scan_renderer with shortened vertical timing.
// Window w (after posedge w) shows counters ((w-3)%800, (w-3)/800%24).
module tb_vga_scan_renderer;
   import vga_scan_renderer_pkg::*;

   localparam int K_RGB  = 0;
   localparam int K_HS   = 1;
   localparam int K_VS   = 2;
   localparam int K_X    = 3;
   localparam int K_Y    = 4;
   localparam int K_TICK = 5;

   typedef struct {
      int          due;
      int          kind;
      logic [11:0] val;
      string       name;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] entity = ENT_NOTHING;
   logic       game_over = 1'b0;
   logic       game_won = 1'b0;
   logic [9:0] x_out, y_out;
   logic       hsync, vsync, frame_tick;
   logic [3:0] vga_r, vga_g, vga_b;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   vga_scan_renderer #(
      .V_VIS     (20),
      .V_FP      (1),
      .V_SYNC    (2),
      .V_BP      (1),
      .BORDER_PX (8)
   ) dut (
      .vga_clk    (clk),
      .reset      (reset),
      .entity     (entity),
      .game_over  (game_over),
      .game_won   (game_won),
      .x_out      (x_out),
      .y_out      (y_out),
      .hsync      (hsync),
      .vsync      (vsync),
      .vga_r      (vga_r),
      .vga_g      (vga_g),
      .vga_b      (vga_b),
      .frame_tick (frame_tick)
   );

   always #20 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [11:0] actual(input int kind);
      case (kind)
         K_RGB:   return {vga_r, vga_g, vga_b};
         K_HS:    return {11'd0, hsync};
         K_VS:    return {11'd0, vsync};
         K_X:     return {2'd0, x_out};
         K_Y:     return {2'd0, y_out};
         default: return {11'd0, frame_tick};
      endcase
   endfunction

   task automatic expect_at(input int due, input int kind,
                            input logic [11:0] val, input string name);
      exp_t e;
      int   i;
      e = '{due, kind, val, name};
      i = sb.size();
      while (i > 0 && sb[i-1].due > due) i--;
      sb.insert(i, e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Answer a pixel query one cycle after its counter window
   task automatic ent_at(input int w, input logic [1:0] code,
                         input logic [11:0] val, input string name);
      wait_until(w);
      entity = code;
      expect_at(w + 1, K_RGB, val, name);
      wait_until(w + 1);
      entity = ENT_NOTHING;
   endtask

   // Monitor: compare every expectation that falls due in this window
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         logic [11:0] a;
         e = sb.pop_front();
         a = actual(e.kind);
         checks++;
         if (e.due < cyc) begin
            failures++;
            $display("FAIL %s missed due=%0d now=%0d", e.name, e.due, cyc);
         end else if (a !== e.val) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h",
                     e.name, cyc, a, e.val);
         end
      end
   end

   initial begin
      wait_until(3);
      reset = 1'b0;

      expect_at(3, K_X,    12'd0,   "rst_x");
      expect_at(3, K_Y,    12'd0,   "rst_y");
      expect_at(3, K_HS,   12'd1,   "rst_hsync");
      expect_at(3, K_VS,   12'd1,   "rst_vsync");
      expect_at(3, K_RGB,  12'h000, "rst_rgb0");
      expect_at(3, K_TICK, 12'd0,   "rst_tick");
      expect_at(4, K_RGB,  12'h000, "rst_rgb1");
      expect_at(5, K_RGB,  12'h888, "first_px_wall");

      expect_at(659, K_X,  12'd656, "x_656");
      expect_at(660, K_HS, 12'd1,   "hs_before");
      expect_at(661, K_HS, 12'd0,   "hs_fall");
      expect_at(756, K_HS, 12'd0,   "hs_last_low");
      expect_at(757, K_HS, 12'd1,   "hs_rise");
      expect_at(802, K_X,  12'd799, "x_799");
      expect_at(802, K_Y,  12'd0,   "y_line0");
      expect_at(803, K_X,  12'd0,   "x_wrap");
      expect_at(803, K_Y,  12'd1,   "y_inc");

      expect_at(6005,  K_RGB, 12'h888, "top_wall");
      expect_at(6805,  K_RGB, 12'h000, "first_inner_row");
      expect_at(7210,  K_RGB, 12'h888, "left_wall");
      expect_at(7303,  K_X,   12'd100, "x_100");
      expect_at(7303,  K_Y,   12'd9,   "y_9");
      expect_at(7605,  K_RGB, 12'h000, "bg_normal");
      expect_at(7836,  K_RGB, 12'h000, "inner_x631");
      expect_at(7837,  K_RGB, 12'h888, "right_wall");
      expect_at(7905,  K_RGB, 12'h000, "hblank");
      expect_at(15505, K_RGB, 12'h888, "bottom_wall");

      expect_at(16002, K_TICK, 12'd0,  "tick_pre");
      expect_at(16003, K_TICK, 12'd1,  "tick0");
      expect_at(16003, K_X,    12'd0,  "tick_x");
      expect_at(16003, K_Y,    12'd20, "tick_y");
      expect_at(16004, K_TICK, 12'd0,  "tick_post");
      expect_at(16804, K_VS,   12'd1,  "vs_before");
      expect_at(16805, K_VS,   12'd0,  "vs_fall");
      expect_at(18404, K_VS,   12'd0,  "vs_last_low");
      expect_at(18405, K_VS,   12'd1,  "vs_rise");
      expect_at(35202, K_TICK, 12'd0,  "tick1_pre");
      expect_at(35203, K_TICK, 12'd1,  "tick1");

      ent_at(7304, ENT_APPLE,      12'hF00, "apple");
      ent_at(7404, ENT_SNAKE_HEAD, 12'h0F0, "head");
      ent_at(7504, ENT_SNAKE_TAIL, 12'h0A0, "tail");
      ent_at(8007, ENT_APPLE,      12'hF00, "apple_on_wall");
      ent_at(8704, ENT_APPLE,      12'h000, "apple_blank");

      wait_until(16000);
      game_won = 1'b1;
      expect_at(26805, K_RGB, 12'h004, "bg_won");

      wait_until(27253);
      game_over = 1'b1;
      expect_at(27605, K_RGB, 12'h004, "no_tear");
      expect_at(45610, K_RGB, 12'h888, "wall_over");
      expect_at(46005, K_RGB, 12'h400, "bg_over_both");

      ent_at(45704, ENT_APPLE, 12'hF00, "apple_over");

      wait_until(46703);
      reset     = 1'b1;
      game_over = 1'b0;
      game_won  = 1'b0;
      wait_until(46704);
      reset = 1'b0;
      expect_at(46704, K_X,    12'd0,   "mid_rst_x");
      expect_at(46704, K_Y,    12'd0,   "mid_rst_y");
      expect_at(46704, K_HS,   12'd1,   "mid_rst_hs");
      expect_at(46704, K_VS,   12'd1,   "mid_rst_vs");
      expect_at(46704, K_RGB,  12'h000, "mid_rst_rgb0");
      expect_at(46704, K_TICK, 12'd0,   "mid_rst_tick");
      expect_at(46705, K_RGB,  12'h000, "mid_rst_rgb1");
      expect_at(46706, K_RGB,  12'h888, "mid_rst_px");
      expect_at(54306, K_RGB,  12'h000, "latch_normal");
      expect_at(54403, K_TICK, 12'd0,   "no_old_tick");

      wait_until(54410);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         failures++;
         $display("FAIL %s never_checked due=%0d", e.name, e.due);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
